// File: rtl/wb_ram_loader_pkg.sv
// Shared types and constants for the Wishbone RAM preloader.
package wb_ram_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      COLLECT,
      WRITE,
      DONE,
      ERR
   } state_e;

   localparam int unsigned HDR_BYTES = 2;
   localparam logic [3:0]  BE_ALL    = 4'hF;

endpackage

// File: rtl/wb_ram_loader_pack.sv
// Little-endian byte-to-word packer; full_o flags the push that completes a word.
module wb_ram_loader_pack (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        full_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] buf_q, buf_d;

   always_comb begin
      cnt_d = cnt_q;
      buf_d = buf_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (push_i) begin
         buf_d[{cnt_q, 3'b000} +: 8] = byte_i;
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         buf_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         buf_q <= buf_d;
      end
   end

   assign word_o = buf_q;
   assign full_o = push_i & (cnt_q == 2'd3);

endmodule

// File: rtl/wb_ram_loader.sv
// Streams a length-prefixed byte image into block RAM over Wishbone, holding the CPU in reset until done.
module wb_ram_loader
   import wb_ram_loader_pkg::*;
#(
   parameter int unsigned DEPTH   = 128,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [7:0]               byte_dat_i,
   input  logic                     byte_vld_i,
   output logic                     byte_rdy_o,
   output logic                     cyc_o,
   output logic                     stb_o,
   output logic                     we_o,
   output logic [3:0]               be_o,
   output logic [$clog2(DEPTH)-1:0] adr_o,
   output logic [31:0]              dat_o,
   input  logic                     ack_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     cpu_rst_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned LW = 8 * HDR_BYTES;

   state_e          state_q;
   logic [7:0]      len_lo_q;
   logic [LW-1:0]   rem_q;
   logic [AW-1:0]   idx_q;
   logic [TW-1:0]   tmo_q;
   logic            cyc_q, stb_q, rdy_q, busy_q, done_q, err_q, cpu_rst_q;
   logic [3:0]      be_q;

   logic [LW-1:0]   hdr_len;
   logic            accept;
   logic            pack_push, pack_clr, pack_full;
   logic [31:0]     pack_word;

   assign hdr_len   = {byte_dat_i, len_lo_q};
   assign accept    = byte_vld_i & rdy_q;
   assign pack_push = accept & (state_q == COLLECT);
   assign pack_clr  = (state_q == HDR1);

   wb_ram_loader_pack u_pack (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (pack_clr),
      .push_i (pack_push),
      .byte_i (byte_dat_i),
      .word_o (pack_word),
      .full_o (pack_full)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         len_lo_q  <= '0;
         rem_q     <= '0;
         idx_q     <= '0;
         tmo_q     <= '0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         be_q      <= '0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cpu_rst_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE, DONE, ERR: begin
               if (start_i) begin
                  state_q   <= HDR0;
                  rdy_q     <= 1'b1;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  err_q     <= 1'b0;
                  cpu_rst_q <= 1'b1;
               end
            end
            HDR0: begin
               if (accept) begin
                  len_lo_q <= byte_dat_i;
                  state_q  <= HDR1;
               end
            end
            HDR1: begin
               if (accept) begin
                  if (hdr_len == '0) begin
                     state_q   <= DONE;
                     rdy_q     <= 1'b0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     cpu_rst_q <= 1'b0;
                  end else if (32'(hdr_len) > DEPTH) begin
                     state_q <= ERR;
                     rdy_q   <= 1'b0;
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                  end else begin
                     rem_q   <= hdr_len;
                     idx_q   <= '0;
                     state_q <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               // rdy is held low for one cycle after each ack so strobes never abut
               if (!rdy_q) begin
                  rdy_q <= 1'b1;
               end else if (pack_full) begin
                  state_q <= WRITE;
                  rdy_q   <= 1'b0;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  be_q    <= BE_ALL;
                  tmo_q   <= '0;
               end
            end
            WRITE: begin
               if (ack_i) begin
                  cyc_q <= 1'b0;
                  stb_q <= 1'b0;
                  be_q  <= '0;
                  idx_q <= idx_q + 1'b1;
                  rem_q <= rem_q - 1'b1;
                  if (rem_q == LW'(1)) begin
                     state_q   <= DONE;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     cpu_rst_q <= 1'b0;
                  end else begin
                     state_q <= COLLECT;
                  end
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  be_q    <= '0;
                  state_q <= ERR;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign byte_rdy_o = rdy_q;
   assign cyc_o      = cyc_q;
   assign stb_o      = stb_q;
   assign we_o       = stb_q;
   assign be_o       = be_q;
   assign adr_o      = idx_q;
   assign dat_o      = pack_word;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign cpu_rst_o  = cpu_rst_q;

endmodule

// File: tb/tb_wb_ram_loader.sv
// Self-checking bench for wb_ram_loader: random images, stalling Wishbone slave, error and reset cases.
module tb_wb_ram_loader;

   localparam int DEPTH   = 128;
   localparam int TIMEOUT = 16;
   localparam int AW      = 7;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic [7:0]    byte_dat_i = '0;
   logic          byte_vld_i = 1'b0;
   logic          byte_rdy_o;
   logic          cyc_o, stb_o, we_o;
   logic [3:0]    be_o;
   logic [AW-1:0] adr_o;
   logic [31:0]   dat_o;
   logic          ack_i = 1'b0;
   logic          busy_o, done_o, err_o, cpu_rst_o;

   wb_ram_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .byte_dat_i (byte_dat_i),
      .byte_vld_i (byte_vld_i),
      .byte_rdy_o (byte_rdy_o),
      .cyc_o      (cyc_o),
      .stb_o      (stb_o),
      .we_o       (we_o),
      .be_o       (be_o),
      .adr_o      (adr_o),
      .dat_o      (dat_o),
      .ack_i      (ack_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .cpu_rst_o  (cpu_rst_o)
   );

   always #5 clk = ~clk;

   int asserts = 0;
   int fails   = 0;

   // slave controls (written only by the test sequence)
   bit never_ack = 1'b0;
   int ack_delay = 0;

   // slave / bus monitor state (written only by the negedge process)
   int            cyc_n = 0;
   int            wait_n = 0;
   logic          prev_stb = 1'b0, prev_ack = 1'b0, prev_err = 1'b0, prev_done = 1'b0;
   logic [AW-1:0] cap_adr = '0;
   logic [31:0]   cap_dat = '0;
   int            stab_viol = 0, gap_viol = 0, attr_viol = 0, rst_viol = 0, cyc_cnt = 0;
   int            stb_rise_cyc = 0, err_rise_cyc = 0, done_rise_cyc = 0, last_ack_cyc = 0;
   logic [AW-1:0] log_adr[$];
   logic [31:0]   log_dat[$];
   logic [31:0]   ram[DEPTH];

   // stimulus image and reference expectations
   logic [7:0]    byte_q[$];
   logic [31:0]   exp_words[$];
   bit            exp_err;

   always @(negedge clk) begin
      cyc_n++;
      if (rst_i) begin
         ack_i    = 1'b0;
         wait_n   = 0;
         prev_stb = 1'b0;
         prev_ack = 1'b0;
      end else begin
         prev_ack = ack_i;
         if (cyc_o) cyc_cnt++;
         if (busy_o && !cpu_rst_o) rst_viol++;
         if (err_o && !prev_err) err_rise_cyc = cyc_n;
         if (done_o && !prev_done) done_rise_cyc = cyc_n;
         if (stb_o && prev_ack) gap_viol++;
         if (stb_o) begin
            if (!cyc_o || !we_o || be_o !== 4'hF) attr_viol++;
            if (!prev_stb) begin
               cap_adr      = adr_o;
               cap_dat      = dat_o;
               stb_rise_cyc = cyc_n;
            end else if (adr_o !== cap_adr || dat_o !== cap_dat) begin
               stab_viol++;
            end
         end
         if (stb_o && !prev_ack) begin
            if (!never_ack && wait_n >= ack_delay) begin
               ack_i = 1'b1;
               ram[adr_o] = dat_o;
               log_adr.push_back(adr_o);
               log_dat.push_back(dat_o);
               last_ack_cyc = cyc_n;
            end
            wait_n++;
         end else begin
            ack_i  = 1'b0;
            wait_n = 0;
         end
         prev_stb = stb_o;
      end
      prev_err  = err_o;
      prev_done = done_o;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: time limit reached, required run to finish");
      $fatal(1);
   end

   // Reference: header is a little-endian count, each word is 4 little-endian bytes at index 0..N-1.
   task automatic model;
      int n;
      n = int'(byte_q[0]) + 256 * int'(byte_q[1]);
      exp_err = (n > DEPTH);
      exp_words.delete();
      if (!exp_err)
         for (int w = 0; w < n; w++)
            exp_words.push_back({byte_q[4*w+5], byte_q[4*w+4], byte_q[4*w+3], byte_q[4*w+2]});
   endtask

   task automatic make_image(input int n);
      logic [15:0] nn;
      nn = 16'(n);
      byte_q.delete();
      byte_q.push_back(nn[7:0]);
      byte_q.push_back(nn[15:8]);
      for (int i = 0; i < 4 * n; i++) byte_q.push_back(8'($urandom));
   endtask

   task automatic pulse_start;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic send_all(input int unsigned gap);
      int t;
      foreach (byte_q[i]) begin
         if (gap > 0) begin
            byte_vld_i = 1'b0;
            repeat ($urandom_range(gap, 0)) @(negedge clk);
         end
         byte_dat_i = byte_q[i];
         byte_vld_i = 1'b1;
         t = 0;
         while (!byte_rdy_o && t < 300) begin
            @(negedge clk);
            t++;
         end
         if (t >= 300) begin
            asserts++;
            fails++;
            $display("FAIL byte_accept: byte %0d never accepted, byte_rdy_o=%b required 1", i, byte_rdy_o);
            byte_vld_i = 1'b0;
            return;
         end
         @(negedge clk);
      end
      byte_vld_i = 1'b0;
   endtask

   task automatic wait_end;
      int t;
      t = 0;
      while (!(done_o || err_o) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         asserts++;
         fails++;
         $display("FAIL load_end: done_o=%b err_o=%b, required one of them 1", done_o, err_o);
      end
      #1;
   endtask

   task automatic run_load(input int unsigned gap);
      pulse_start();
      send_all(gap);
      wait_end();
   endtask

   task automatic do_reset;
      rst_i = 1'b1;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      asserts++;
      if ({cyc_o, stb_o, we_o, be_o, adr_o, dat_o, busy_o, done_o, err_o, byte_rdy_o} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: cyc=%b stb=%b we=%b be=%h adr=%h dat=%h busy=%b done=%b err=%b rdy=%b, required all 0",
                  cyc_o, stb_o, we_o, be_o, adr_o, dat_o, busy_o, done_o, err_o, byte_rdy_o);
      end
      asserts++;
      if (cpu_rst_o !== 1'b1) begin
         fails++;
         $display("FAIL reset_cpu_rst: cpu_rst_o=%b required 1", cpu_rst_o);
      end
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      asserts++;
      if ({busy_o, byte_rdy_o, cpu_rst_o} !== 3'b001) begin
         fails++;
         $display("FAIL idle_hold: busy/rdy/cpu_rst=%b required 001", {busy_o, byte_rdy_o, cpu_rst_o});
      end
      pulse_start();
      asserts++;
      if ({busy_o, byte_rdy_o, cpu_rst_o} !== 3'b111) begin
         fails++;
         $display("FAIL start_hdr0: busy/rdy/cpu_rst=%b required 111", {busy_o, byte_rdy_o, cpu_rst_o});
      end
      do_reset();
   endtask

   task automatic test_load3;
      int base, rv0, av0;
      byte_q = '{8'h03, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                 8'h01, 8'h00, 8'h00, 8'h00};
      model();
      base = log_adr.size();
      rv0  = rst_viol;
      av0  = attr_viol;
      ack_delay = 0;
      run_load(0);
      asserts++;
      if ({done_o, err_o, busy_o, cpu_rst_o} !== 4'b1000) begin
         fails++;
         $display("FAIL load3_flags: done/err/busy/cpu_rst=%b required 1000", {done_o, err_o, busy_o, cpu_rst_o});
      end
      asserts++;
      if (log_adr.size() - base != 3) begin
         fails++;
         $display("FAIL load3_count: %0d writes, required 3", log_adr.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            asserts++;
            if (log_adr[base+i] !== AW'(i) || log_dat[base+i] !== exp_words[i] || ram[i] !== exp_words[i]) begin
               fails++;
               $display("FAIL load3_word%0d: adr=%0d dat=%h ram=%h, required adr=%0d dat=%h",
                        i, log_adr[base+i], log_dat[base+i], ram[i], i, exp_words[i]);
            end
         end
      end
      asserts++;
      if (done_rise_cyc != last_ack_cyc + 1) begin
         fails++;
         $display("FAIL load3_done_timing: done at cycle %0d, required %0d (after last ack)",
                  done_rise_cyc, last_ack_cyc + 1);
      end
      asserts++;
      if (rst_viol != rv0 || attr_viol != av0) begin
         fails++;
         $display("FAIL load3_bus_attr: cpu_rst drops while busy=%0d bad we/be/cyc=%0d, required 0 0",
                  rst_viol - rv0, attr_viol - av0);
      end
   endtask

   task automatic test_len_err;
      int c0, base;
      byte_q = '{8'h81, 8'h00};
      c0   = cyc_cnt;
      base = log_adr.size();
      run_load(0);
      asserts++;
      if ({err_o, done_o, busy_o, cpu_rst_o, byte_rdy_o} !== 5'b10010) begin
         fails++;
         $display("FAIL len_err_flags: err/done/busy/cpu_rst/rdy=%b required 10010",
                  {err_o, done_o, busy_o, cpu_rst_o, byte_rdy_o});
      end
      asserts++;
      if (cyc_cnt != c0 || log_adr.size() != base) begin
         fails++;
         $display("FAIL len_err_bus: %0d cyc cycles, %0d writes, required 0 0", cyc_cnt - c0, log_adr.size() - base);
      end
   endtask

   task automatic test_zero_restart;
      int c0, base;
      byte_q = '{8'h00, 8'h00};
      c0   = cyc_cnt;
      base = log_adr.size();
      run_load(0);
      asserts++;
      if ({done_o, err_o, cpu_rst_o} !== 3'b100 || cyc_cnt != c0) begin
         fails++;
         $display("FAIL zero_len: done/err/cpu_rst=%b cyc cycles=%0d, required 100 and 0",
                  {done_o, err_o, cpu_rst_o}, cyc_cnt - c0);
      end
      pulse_start();
      asserts++;
      if ({cpu_rst_o, done_o, busy_o} !== 3'b101) begin
         fails++;
         $display("FAIL restart_flags: cpu_rst/done/busy=%b required 101", {cpu_rst_o, done_o, busy_o});
      end
      make_image(1);
      model();
      send_all(0);
      wait_end();
      asserts++;
      if (log_adr.size() != base + 1) begin
         fails++;
         $display("FAIL restart_count: %0d writes, required 1", log_adr.size() - base);
      end else if (log_adr[base] !== '0 || log_dat[base] !== exp_words[0] || done_o !== 1'b1) begin
         fails++;
         $display("FAIL restart_word: adr=%0d dat=%h done=%b, required adr=0 dat=%h done=1",
                  log_adr[base], log_dat[base], done_o, exp_words[0]);
      end
   endtask

   task automatic test_images(input int iters, input int nmax, input int gmax, input int dmax, input bit stall);
      int base, sv0, gv0, bad, n;
      for (int it = 0; it < iters; it++) begin
         n = stall ? 4 : $urandom_range(nmax, 1);
         make_image(n);
         model();
         ack_delay = stall ? 5 : $urandom_range(dmax, 0);
         base = log_adr.size();
         sv0  = stab_viol;
         gv0  = gap_viol;
         run_load(stall ? 4 : $urandom_range(gmax, 0));
         bad = 0;
         if (log_adr.size() - base == n)
            for (int i = 0; i < n; i++)
               if (log_adr[base+i] !== AW'(i) || log_dat[base+i] !== exp_words[i]) bad++;
         asserts++;
         if (log_adr.size() - base != n || bad != 0 || done_o !== 1'b1) begin
            fails++;
            $display("FAIL image_n%0d: writes=%0d bad_words=%0d done=%b, required writes=%0d bad=0 done=1",
                     n, log_adr.size() - base, bad, done_o, n);
         end
         asserts++;
         if (stab_viol != sv0 || gap_viol != gv0) begin
            fails++;
            $display("FAIL bus_stability_n%0d: unstable adr/dat=%0d back-to-back stb=%0d, required 0 0",
                     n, stab_viol - sv0, gap_viol - gv0);
         end
      end
   endtask

   task automatic test_full_depth;
      int base, bad;
      make_image(DEPTH);
      model();
      ack_delay = 0;
      base = log_adr.size();
      run_load(0);
      bad = 0;
      if (log_adr.size() - base == DEPTH)
         for (int i = 0; i < DEPTH; i++)
            if (log_adr[base+i] !== AW'(i) || ram[i] !== exp_words[i]) bad++;
      asserts++;
      if (log_adr.size() - base != DEPTH || bad != 0 || {done_o, err_o} !== 2'b10) begin
         fails++;
         $display("FAIL full_depth: writes=%0d bad=%0d done/err=%b, required writes=%0d bad=0 done/err=10",
                  log_adr.size() - base, bad, {done_o, err_o}, DEPTH);
      end
   endtask

   task automatic test_timeout;
      int t;
      never_ack = 1'b1;
      make_image(1);
      pulse_start();
      send_all(0);
      t = 0;
      while (!err_o && t < 200) begin
         @(negedge clk);
         t++;
      end
      #1;
      asserts++;
      if (err_o !== 1'b1 || err_rise_cyc - stb_rise_cyc != TIMEOUT) begin
         fails++;
         $display("FAIL timeout_latency: err=%b after %0d cycles, required err=1 after %0d",
                  err_o, err_rise_cyc - stb_rise_cyc, TIMEOUT);
      end
      asserts++;
      if ({cyc_o, stb_o, cpu_rst_o, done_o, busy_o} !== 5'b00100) begin
         fails++;
         $display("FAIL timeout_bus: cyc/stb/cpu_rst/done/busy=%b required 00100",
                  {cyc_o, stb_o, cpu_rst_o, done_o, busy_o});
      end
      never_ack = 1'b0;
   endtask

   task automatic test_async_reset;
      int base;
      never_ack = 1'b1;
      make_image(2);
      byte_q = byte_q[0:5];
      pulse_start();
      send_all(0);
      asserts++;
      if (stb_o !== 1'b1) begin
         fails++;
         $display("FAIL areset_precond: stb_o=%b required 1", stb_o);
      end
      #2 rst_i = 1'b1;
      #1;
      asserts++;
      if ({cyc_o, stb_o, cpu_rst_o, busy_o} !== 4'b0010) begin
         fails++;
         $display("FAIL areset_async: cyc/stb/cpu_rst/busy=%b required 0010", {cyc_o, stb_o, cpu_rst_o, busy_o});
      end
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      asserts++;
      if ({byte_rdy_o, busy_o, done_o, err_o, cpu_rst_o} !== 5'b00001) begin
         fails++;
         $display("FAIL areset_idle: rdy/busy/done/err/cpu_rst=%b required 00001",
                  {byte_rdy_o, busy_o, done_o, err_o, cpu_rst_o});
      end
      never_ack = 1'b0;
      make_image(2);
      model();
      ack_delay = 1;
      base = log_adr.size();
      run_load(1);
      asserts++;
      if (log_adr.size() != base + 2) begin
         fails++;
         $display("FAIL areset_reload_count: %0d writes, required 2", log_adr.size() - base);
      end else if (log_dat[base] !== exp_words[0] || log_dat[base+1] !== exp_words[1] ||
                   log_adr[base+1] !== AW'(1) || done_o !== 1'b1) begin
         fails++;
         $display("FAIL areset_reload: dat0=%h dat1=%h adr1=%0d done=%b, required %h %h 1 1",
                  log_dat[base], log_dat[base+1], log_adr[base+1], done_o, exp_words[0], exp_words[1]);
      end
   endtask

   initial begin
      test_reset();
      test_load3();
      test_len_err();
      test_zero_restart();
      test_images(2, 4, 0, 0, 1'b1);
      test_images(5, 8, 3, 6, 1'b0);
      test_full_depth();
      test_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
